// File: rtl/alu_arbiter_pkg.sv
// Shared ALU opcodes, widths and slot state for the
// two-requester ALU arbiter.
package alu_arbiter_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int ALU_NUM_REQ    = 2;

  localparam logic [3:0] ALU_ADD     = 4'd0;
  localparam logic [3:0] ALU_SUB     = 4'd1;
  localparam logic [3:0] ALU_AND     = 4'd2;
  localparam logic [3:0] ALU_OR      = 4'd3;
  localparam logic [3:0] ALU_XOR     = 4'd4;
  localparam logic [3:0] ALU_SLL     = 4'd5;
  localparam logic [3:0] ALU_SRL     = 4'd6;
  localparam logic [3:0] ALU_SRA     = 4'd7;
  localparam logic [3:0] ALU_SLT     = 4'd8;
  localparam logic [3:0] ALU_SLTU    = 4'd9;
  localparam logic [3:0] ALU_INVALID = 4'd15;

  localparam logic [31:0] ALU_DEFAULT = 32'hDEADBEEF;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_e;

  // Codes 10..14 are unassigned, 15 is explicitly invalid.
  function automatic logic alu_op_legal(logic [3:0] op);
    return op <= ALU_SLTU;
  endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational ALU shared by both requesters.
// Unknown opcodes return the ALU_DEFAULT pattern.
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic [3:0]            op_i,
  output logic [DATA_WIDTH-1:0] y_o
);

  logic [4:0] shamt;
  logic       lt_s;
  logic       lt_u;

  assign shamt = b_i[4:0];
  assign lt_s  = $signed(a_i) < $signed(b_i);
  assign lt_u  = a_i < b_i;

  always_comb begin
    y_o = DATA_WIDTH'(ALU_DEFAULT);
    case (op_i)
      ALU_ADD:  y_o = a_i + b_i;
      ALU_SUB:  y_o = a_i - b_i;
      ALU_AND:  y_o = a_i & b_i;
      ALU_OR:   y_o = a_i | b_i;
      ALU_XOR:  y_o = a_i ^ b_i;
      ALU_SLL:  y_o = a_i << shamt;
      ALU_SRL:  y_o = a_i >> shamt;
      ALU_SRA:  y_o = DATA_WIDTH'($signed(a_i) >>> shamt);
      ALU_SLT:  y_o = {{(DATA_WIDTH-1){1'b0}}, lt_s};
      ALU_SLTU: y_o = {{(DATA_WIDTH-1){1'b0}}, lt_u};
      default:  y_o = DATA_WIDTH'(ALU_DEFAULT);
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two
// requesters, with a single registered response slot.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rq0_valid,
  output logic                  rq0_ready,
  input  logic [DATA_WIDTH-1:0] rq0_a,
  input  logic [DATA_WIDTH-1:0] rq0_b,
  input  logic [3:0]            rq0_op,
  input  logic                  rq1_valid,
  output logic                  rq1_ready,
  input  logic [DATA_WIDTH-1:0] rq1_a,
  input  logic [DATA_WIDTH-1:0] rq1_b,
  input  logic [3:0]            rq1_op,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_id,
  output logic [DATA_WIDTH-1:0] rsp_result,
  output logic                  rsp_err
);

  slot_e                 state_q, state_d;
  logic                  last_q, last_d;
  logic                  id_q, id_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] res_q, res_d;

  logic                  slot_free;
  logic                  grant;
  logic                  accept;
  logic [DATA_WIDTH-1:0] alu_a, alu_b, alu_y;
  logic [3:0]            alu_op;

  assign slot_free = (state_q == SLOT_EMPTY) || rsp_ready;

  // On a tie the requester not served last wins.
  always_comb begin
    grant = 1'b0;
    if (rq0_valid && rq1_valid) begin
      grant = ~last_q;
    end else if (rq1_valid) begin
      grant = 1'b1;
    end
  end

  assign rq0_ready = !grant && rq0_valid
                   && slot_free && rst_n;
  assign rq1_ready = grant && rq1_valid
                   && slot_free && rst_n;
  assign accept    = rq0_ready || rq1_ready;

  assign alu_a  = grant ? rq1_a  : rq0_a;
  assign alu_b  = grant ? rq1_b  : rq0_b;
  assign alu_op = grant ? rq1_op : rq0_op;

  alu_arbiter_alu #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_alu (
    .a_i (alu_a),
    .b_i (alu_b),
    .op_i(alu_op),
    .y_o (alu_y)
  );

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    id_d    = id_q;
    err_d   = err_q;
    res_d   = res_q;
    if (accept) begin
      state_d = SLOT_FULL;
      last_d  = grant;
      id_d    = grant;
      err_d   = !alu_op_legal(alu_op);
      res_d   = alu_y;
    end else if (state_q == SLOT_FULL && rsp_ready) begin
      state_d = SLOT_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= SLOT_EMPTY;
      last_q  <= 1'b1;
      id_q    <= 1'b0;
      err_q   <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      err_q   <= err_d;
      res_q   <= res_d;
    end
  end

  assign rsp_valid  = (state_q == SLOT_FULL);
  assign rsp_id     = id_q;
  assign rsp_err    = err_q;
  assign rsp_result = res_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: vector table, directed corner
// sequences and randomized traffic against a reference model.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rq0_valid, rq0_ready;
  logic [31:0] rq0_a, rq0_b;
  logic [3:0]  rq0_op;
  logic        rq1_valid, rq1_ready;
  logic [31:0] rq1_a, rq1_b;
  logic [3:0]  rq1_op;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [31:0] rsp_result;

  int checks = 0;
  int errs   = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .rq0_valid(rq0_valid), .rq0_ready(rq0_ready),
    .rq0_a(rq0_a), .rq0_b(rq0_b), .rq0_op(rq0_op),
    .rq1_valid(rq1_valid), .rq1_ready(rq1_ready),
    .rq1_a(rq1_a), .rq1_b(rq1_b), .rq1_op(rq1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_err(rsp_err)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [31:0] res;
    logic        err;
  } vec_t;

  // Reference model state: what the response slot should hold.
  logic        m_valid, m_id, m_err, m_last;
  logic [31:0] m_res;
  logic        acc0, acc1;

  function automatic logic [31:0] ref_alu(
    logic [31:0] a, logic [31:0] b, logic [3:0] op);
    int unsigned sh;
    sh = b % 32;
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return a << sh;
      4'd6: return a >> sh;
      4'd7: return $unsigned($signed(a) >>> sh);
      4'd8: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9: return (a < b) ? 32'd1 : 32'd0;
      default: return 32'hDEADBEEF;
    endcase
  endfunction

  task automatic chk(string n, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic set0(logic v, logic [31:0] a,
                      logic [31:0] b, logic [3:0] op);
    rq0_valid = v; rq0_a = a; rq0_b = b; rq0_op = op;
  endtask

  task automatic set1(logic v, logic [31:0] a,
                      logic [31:0] b, logic [3:0] op);
    rq1_valid = v; rq1_a = a; rq1_b = b; rq1_op = op;
  endtask

  // One clock: check readies before the edge, then the slot.
  task automatic step();
    logic free, win, e0, e1;
    #1;
    free = !m_valid || rsp_ready;
    if (rq0_valid && rq1_valid) win = !m_last;
    else win = rq1_valid;
    e0 = rst_n && free && rq0_valid && !win;
    e1 = rst_n && free && rq1_valid && win;
    chk("rq0_ready", {31'd0, rq0_ready}, {31'd0, e0});
    chk("rq1_ready", {31'd0, rq1_ready}, {31'd0, e1});
    acc0 = rq0_valid && rq0_ready;
    acc1 = rq1_valid && rq1_ready;
    @(posedge clk);
    if (!rst_n) begin
      m_valid = 0; m_id = 0; m_res = 0;
      m_err = 0; m_last = 1;
    end else if (e0 || e1) begin
      m_valid = 1;
      m_id    = e1;
      m_last  = e1;
      m_res   = e1 ? ref_alu(rq1_a, rq1_b, rq1_op)
                   : ref_alu(rq0_a, rq0_b, rq0_op);
      m_err   = e1 ? (rq1_op > 4'd9) : (rq0_op > 4'd9);
    end else if (m_valid && rsp_ready) begin
      m_valid = 0;
    end
    #1;
    chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_valid});
    chk("rsp_id", {31'd0, rsp_id}, {31'd0, m_id});
    chk("rsp_err", {31'd0, rsp_err}, {31'd0, m_err});
    chk("rsp_result", rsp_result, m_res);
  endtask

  task automatic drain_reqs();
    rsp_ready = 1;
    repeat (4) begin
      step();
      if (acc0) rq0_valid = 0;
      if (acc1) rq1_valid = 0;
    end
  endtask

  // Requesters must hold valid and payload until accepted.
  logic        p0 = 0, p1 = 0;
  logic [39:0] s0, s1;
  always @(posedge clk) begin
    if (rst_n && p0) begin
      checks++;
      if (!rq0_valid || {rq0_a, rq0_b[3:0], rq0_op} !== s0) begin
        errs++;
        $display("FAIL rq0_hold: payload changed before accept");
      end
    end
    if (rst_n && p1) begin
      checks++;
      if (!rq1_valid || {rq1_a, rq1_b[3:0], rq1_op} !== s1) begin
        errs++;
        $display("FAIL rq1_hold: payload changed before accept");
      end
    end
    p0 = rst_n && rq0_valid && !rq0_ready;
    p1 = rst_n && rq1_valid && !rq1_ready;
    s0 = {rq0_a, rq0_b[3:0], rq0_op};
    s1 = {rq1_a, rq1_b[3:0], rq1_op};
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t        vt[13];
    logic [31:0] snap;
    logic        eid;

    vt[0]  = '{32'd5, 32'd7, ALU_ADD, 32'd12, 1'b0};
    vt[1]  = '{32'd10, 32'd3, ALU_SUB, 32'd7, 1'b0};
    vt[2]  = '{32'hFFFFFFFF, 32'd1, ALU_SLT, 32'd1, 1'b0};
    vt[3]  = '{32'hFFFFFFFF, 32'd1, ALU_SLTU, 32'd0, 1'b0};
    vt[4]  = '{32'hF0F0F0F0, 32'hFF00FF00, ALU_AND,
               32'hF000F000, 1'b0};
    vt[5]  = '{32'hF0F0F0F0, 32'h0F0F0000, ALU_OR,
               32'hFFFFF0F0, 1'b0};
    vt[6]  = '{32'hFFFF0000, 32'h0F0F0F0F, ALU_XOR,
               32'hF0F00F0F, 1'b0};
    vt[7]  = '{32'd1, 32'd33, ALU_SLL, 32'd2, 1'b0};
    vt[8]  = '{32'h80000000, 32'd4, ALU_SRL,
               32'h08000000, 1'b0};
    vt[9]  = '{32'h80000000, 32'd4, ALU_SRA,
               32'hF8000000, 1'b0};
    vt[10] = '{32'd1, 32'd2, ALU_INVALID,
               32'hDEADBEEF, 1'b1};
    vt[11] = '{32'd1, 32'd2, 4'd10, 32'hDEADBEEF, 1'b1};
    vt[12] = '{32'hFFFFFFFF, 32'd1, ALU_ADD, 32'd0, 1'b0};

    m_valid = 0; m_id = 0; m_res = 0; m_err = 0; m_last = 1;
    acc0 = 0; acc1 = 0;
    rst_n = 0; rsp_ready = 0;
    set0(1, 32'd1, 32'd1, ALU_ADD);
    set1(1, 32'd2, 32'd2, ALU_ADD);
    @(posedge clk); #1;

    // Reset held with both requesters valid.
    repeat (3) step();
    rst_n = 1;
    step();
    chk("first_grant_rq0", {31'd0, acc0}, 32'd1);
    chk("first_grant_id", {31'd0, rsp_id}, 32'd0);
    if (acc0) rq0_valid = 0;
    drain_reqs();

    // Single add.
    set0(1, 32'd5, 32'd7, ALU_ADD);
    step();
    rq0_valid = 0;
    chk("add_result", rsp_result, 32'd12);
    chk("add_id", {31'd0, rsp_id}, 32'd0);
    chk("add_err", {31'd0, rsp_err}, 32'd0);
    drain_reqs();

    // Contention: rq0 served last, so rq1 goes first.
    set0(1, 32'd10, 32'd3, ALU_SUB);
    set1(1, 32'hFFFFFFFF, 32'd1, ALU_SLT);
    for (int k = 0; k < 6; k++) begin
      eid = (k % 2 == 0);
      step();
      chk("cont_valid", {31'd0, rsp_valid}, 32'd1);
      chk("cont_id", {31'd0, rsp_id}, {31'd0, eid});
      chk("cont_result", rsp_result, eid ? 32'd1 : 32'd7);
    end
    drain_reqs();

    // Backpressure for 4 cycles.
    set0(1, 32'd20, 32'd22, ALU_ADD);
    step();
    rq0_valid = 0;
    rsp_ready = 0;
    set1(1, 32'd100, 32'd1, ALU_SUB);
    snap = rsp_result;
    chk("bp_first", snap, 32'd42);
    repeat (4) begin
      step();
      chk("bp_hold_result", rsp_result, 32'd42);
      chk("bp_hold_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_no_accept", {31'd0, acc1}, 32'd0);
    end
    rsp_ready = 1;
    step();
    chk("bp_accept_same_cycle", {31'd0, acc1}, 32'd1);
    if (acc1) rq1_valid = 0;
    chk("bp_new_result", rsp_result, 32'd99);
    drain_reqs();

    // Invalid opcode from requester 1.
    set1(1, 32'd5, 32'd5, ALU_INVALID);
    step();
    rq1_valid = 0;
    chk("inv_result", rsp_result, 32'hDEADBEEF);
    chk("inv_err", {31'd0, rsp_err}, 32'd1);
    chk("inv_id", {31'd0, rsp_id}, 32'd1);
    drain_reqs();

    // Reset while a response is stalled.
    set0(1, 32'd3, 32'd4, ALU_ADD);
    step();
    rq0_valid = 0;
    chk("rmo_full", {31'd0, rsp_valid}, 32'd1);
    rsp_ready = 0;
    set1(1, 32'd1, 32'd1, ALU_ADD);
    rst_n = 0;
    step();
    chk("rmo_flushed", {31'd0, rsp_valid}, 32'd0);
    rst_n = 1;
    set0(1, 32'd8, 32'd8, ALU_ADD);
    step();
    chk("rmo_ptr_rq0", {31'd0, acc0}, 32'd1);
    if (acc0) rq0_valid = 0;
    chk("rmo_result", rsp_result, 32'd16);
    drain_reqs();

    // Opcode table through requester 0.
    for (int i = 0; i < 13; i++) begin
      rsp_ready = 1;
      set0(1, vt[i].a, vt[i].b, vt[i].op);
      step();
      rq0_valid = 0;
      chk("vec_result", rsp_result, vt[i].res);
      chk("vec_err", {31'd0, rsp_err}, {31'd0, vt[i].err});
      step();
    end

    // Randomized traffic with random backpressure.
    for (int c = 0; c < 500; c++) begin
      if (acc0 || !rq0_valid)
        set0($urandom_range(0, 2) != 0, $urandom(),
             $urandom(), 4'($urandom_range(0, 15)));
      if (acc1 || !rq1_valid)
        set1($urandom_range(0, 2) != 0, $urandom(),
             $urandom(), 4'($urandom_range(0, 15)));
      rsp_ready = $urandom_range(0, 3) != 0;
      step();
    end
    drain_reqs();

    $display("== %0d vectors applied, %0d miscompares ==",
             checks, errs);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port round-robin arbiter that shares a single `ALU` instance between two requesters, such as the execute stage and the address/branch-target unit. Each requester presents operands and an `ALU_*` opcode on a valid/ready channel. The block grants one request per cycle, registers the ALU result in a single output slot, and returns it on a shared response channel tagged with the requester id. It also flags opcodes that are not legal ALU operations.

## Interface
Parameters:
- DATA_WIDTH, default `DATA_WIDTH (32): operand and result width, passed to `ALU`.

Ports:
- Clock and reset: one clock; reset is synchronous and active-low.
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  synchronous reset, active-low.
- rq0_valid  in  1  requester 0 has a request.
- rq0_ready  out  1  requester 0 request accepted this cycle.
- rq0_a, rq0_b  in  DATA_WIDTH  requester 0 operands.
- rq0_op  in  4  requester 0 ALU select (`ALU_*` code).
- rq1_valid, rq1_ready, rq1_a, rq1_b, rq1_op: same definitions for requester 1.
- rsp_valid  out  1  output slot holds a result.
- rsp_ready  in  1  consumer takes the result this cycle.
- rsp_id  out  1  requester that issued the result.
- rsp_result  out  DATA_WIDTH  registered ALU result.
- rsp_err  out  1  opcode was `ALU_INVALID` or an undefined code.

## Operation
- Output slot:
  - One register set: rsp_valid, rsp_id, rsp_result, rsp_err.
  - Slot is free when `!rsp_valid || rsp_ready`.
- Arbitration:
  - Round-robin pointer `last_grant` (1 bit).
  - Only one requester valid: grant it.
  - Both valid: grant `~last_grant`.
- Ready generation:
  - rqN_ready = (grant == N) && rqN_valid && slot free && rst_n.
  - Combinational. At most one ready is high per cycle.
  - Ready may depend on rqN_valid. Valid must never depend on ready.
- Accept (rqN_valid && rqN_ready at an edge):
  - Mux rqN_a/b/op into the ALU.
  - Register the ALU result into rsp_result.
  - rsp_id ← N, rsp_valid ← 1, last_grant ← N.
  - rsp_err ← 1 if op is `ALU_INVALID` or not a defined `ALU_*` code. rsp_result then carries the ALU default (32'hDEADBEEF).
- Drain without accept: rsp_valid ← 0. rsp_id, rsp_result and rsp_err keep their values.
- Drain and accept in the same cycle: the new result replaces the old one and rsp_valid stays 1.
- Backpressure: while rsp_valid && !rsp_ready, all rsp_* outputs hold stable and both readies are 0.
- Requester rules:
  - Once asserted, rqN_valid stays high with stable a/b/op until accepted.
  - Violations are undefined behaviour. Add an assertion in the bench.
- FSM view (derived from rsp_valid):
  - EMPTY → FULL on accept.
  - FULL → EMPTY on drain without accept.
  - FULL → FULL on drain with accept, or on stall.
- Arithmetic:
  - Width and signedness rules belong to `ALU`; the arbiter adds no logic on the data path.
  - Shift amounts use b[4:0], as `ALU` defines.

## Timing
- Reset values: rsp_valid=0, rsp_id=0, rsp_result=0, rsp_err=0, last_grant=1 (requester 0 wins the first tie). rq0_ready=rq1_ready=0 while rst_n=0.
- Latency: accept at edge N gives rsp_valid=1 with the result after edge N. One cycle.
- Throughput: one result per cycle when rsp_ready is held high.
- Fairness: with both valid continuously and rsp_ready=1, grants alternate 0,1,0,1,… Each requester waits at most one grant.
- Reset mid-operation: a pending response is discarded (rsp_valid=0 at the next edge) and the pointer returns to 1. Requesters must re-present requests.

## Structure
- `ALU_*` opcodes and `DATA_WIDTH` come from the shared `types.sv`.
- Add there: `` `ALU_NUM_REQ `` (2) and the `alu_op_legal` predicate (function or macro) used for rsp_err.
- Sub-module: one `ALU` instance, driven by the granted request's mux. No other sub-modules.
- Expected size about 150 RTL lines.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with both valid. Required: readies 0, rsp_valid 0. First grant after release goes to requester 0.
- Single add: rq0 a=5, b=7, op=`ALU_ADD` → rsp_valid 1 cycle later with rsp_result=12, rsp_id=0, rsp_err=0.
- Contention: both valid continuously, rq0 `ALU_SUB` 10-3, rq1 `ALU_SLT` -1<1, rsp_ready=1. Required: responses alternate id 0,1,0,… with results 7 and 1. No bubbles.
- Backpressure: rsp_ready=0 for 4 cycles after an accept. Required: rsp_* stable and readies 0. When rsp_ready rises, the next accept happens in the same cycle.
- Invalid op: rq1 op=`ALU_INVALID` → rsp_result=32'hDEADBEEF, rsp_err=1, rsp_id=1.
- Reset mid-op: assert rst_n=0 while rsp_valid=1 and rsp_ready=0. Required: rsp_valid=0 the next cycle, and after release the pointer favours requester 0.
